// File: rtl/tetris_input_ctrl.sv
// Button front end for the Tetris field stage: synchronise, debounce, merge with gravity and issue
// one prioritised move pulse per cycle; also picks the next block type from an LFSR.
// Optional held-button auto-repeat for left/right/down is built when TETRIS_AUTO_REPEAT_EN is defined.
module tetris_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned GRAVITY_CYCLES  = 1024,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_RATE     = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btnLeft,
  input  logic       btnRight,
  input  logic       btnDown,
  input  logic       btnRotate,
  input  logic       pause,
  input  logic       gameOver,
  input  logic       nextBlockTrue,
  output logic       leftTrue,
  output logic       rightTrue,
  output logic       downTrue,
  output logic       rotateTrue,
  output logic [2:0] blockType
);

  localparam int unsigned NumBtn    = 4;
  localparam int unsigned IdxRight  = 0;
  localparam int unsigned IdxLeft   = 1;
  localparam int unsigned IdxRotate = 2;
  localparam int unsigned IdxDown   = 3;
  localparam int unsigned DebW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned GravW = (GRAVITY_CYCLES > 1) ? $clog2(GRAVITY_CYCLES) : 1;

  if (DEBOUNCE_CYCLES < 2 || GRAVITY_CYCLES < 2 || REPEAT_DELAY == 0 || REPEAT_RATE == 0)
  begin : gBadConfig
    $error("tetris_input_ctrl: unsupported timing parameters");
  end

  // Button state, bit order {down, rotate, left, right}
  logic [NumBtn-1:0] btnRaw;
  logic [NumBtn-1:0] btnSync1, btnSync2;
  logic [NumBtn-1:0] btnDeb, btnDebNext, btnDebPrev;
  logic [DebW-1:0]   debCnt [NumBtn];
  logic [DebW-1:0]   debCntNext [NumBtn];
  logic [NumBtn-1:0] pressEvt;
  logic [NumBtn-1:0] repeatEvt;
  logic [NumBtn-1:0] btnEvt;
  logic [NumBtn-1:0] evtVec;

  logic              active;
  logic [GravW-1:0]  gravCnt, gravCntNext;
  logic              gravWrap;
  logic              gravEvt;

  logic [NumBtn-1:0] pend, pendNext;
  logic [NumBtn-1:0] issue;
  logic [NumBtn-1:0] pulse;

  logic [7:0]        lfsr, lfsrNext;
  logic [2:0]        lfsrType;
  logic [2:0]        blockTypeNext;

  assign btnRaw = {btnDown, btnRotate, btnLeft, btnRight};
  assign active = ~pause & ~gameOver;

  // Counter reaching DEBOUNCE_CYCLES is detected one step early so it never needs the extra bit.
  always_comb begin
    btnDebNext = btnDeb;
    for (int i = 0; i < NumBtn; i++) begin
      debCntNext[i] = '0;
      if (btnSync2[i] != btnDeb[i]) begin
        if (debCnt[i] == DebW'(DEBOUNCE_CYCLES - 1)) begin
          btnDebNext[i] = ~btnDeb[i];
        end else begin
          debCntNext[i] = debCnt[i] + 1'b1;
        end
      end
    end
  end

  assign pressEvt = btnDeb & ~btnDebPrev;

`ifdef TETRIS_AUTO_REPEAT_EN
  localparam int unsigned NumRpt = 3;
  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RptW   = $clog2(RptMax + 1);

  // Repeat slots map to {down, left, right}; a zero count means not armed.
  logic [RptW-1:0]   rptCnt [NumRpt];
  logic [RptW-1:0]   rptCntNext [NumRpt];
  logic [NumRpt-1:0] rptSeen, rptSeenNext;
  logic [NumRpt-1:0] rptDeb, rptPress, rptEvt;

  assign rptDeb   = {btnDeb[IdxDown], btnDeb[IdxLeft], btnDeb[IdxRight]};
  assign rptPress = {pressEvt[IdxDown], pressEvt[IdxLeft], pressEvt[IdxRight]};

  always_comb begin
    rptSeenNext = rptSeen;
    rptEvt      = '0;
    for (int k = 0; k < NumRpt; k++) begin
      rptCntNext[k] = rptCnt[k];
      if (!rptDeb[k]) begin
        rptCntNext[k]  = '0;
        rptSeenNext[k] = 1'b0;
      end else if (active) begin
        if (rptPress[k]) begin
          rptCntNext[k]  = RptW'(1);
          rptSeenNext[k] = 1'b0;
        end else if (rptCnt[k] != '0) begin
          if (rptCnt[k] == (rptSeen[k] ? RptW'(REPEAT_RATE) : RptW'(REPEAT_DELAY))) begin
            rptEvt[k]      = 1'b1;
            rptCntNext[k]  = RptW'(1);
            rptSeenNext[k] = 1'b1;
          end else begin
            rptCntNext[k] = rptCnt[k] + 1'b1;
          end
        end
      end
    end
  end

  assign repeatEvt = {rptEvt[2], 1'b0, rptEvt[1], rptEvt[0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NumRpt; k++) rptCnt[k] <= '0;
      rptSeen <= '0;
    end else begin
      for (int k = 0; k < NumRpt; k++) rptCnt[k] <= rptCntNext[k];
      rptSeen <= rptSeenNext;
    end
  end
`else
  assign repeatEvt = '0;
`endif

  assign btnEvt   = (pressEvt | repeatEvt) & {NumBtn{active}};
  assign gravWrap = (gravCnt == GravW'(GRAVITY_CYCLES - 1));
  assign gravEvt  = active & gravWrap;

  // A down event restarts the gravity period so the player's step replaces the next drop.
  always_comb begin
    gravCntNext = gravCnt;
    if (active) begin
      if (btnEvt[IdxDown] || gravWrap) begin
        gravCntNext = '0;
      end else begin
        gravCntNext = gravCnt + 1'b1;
      end
    end
  end

  always_comb begin
    evtVec          = btnEvt;
    evtVec[IdxDown] = btnEvt[IdxDown] | gravEvt;
  end

  always_comb begin
    issue = '0;
    if (active) begin
      if (pend[IdxDown])        issue[IdxDown]   = 1'b1;
      else if (pend[IdxRotate]) issue[IdxRotate] = 1'b1;
      else if (pend[IdxLeft])   issue[IdxLeft]   = 1'b1;
      else if (pend[IdxRight])  issue[IdxRight]  = 1'b1;
    end
  end

  // A new event in the issue cycle re-sets the flag, so nothing is dropped.
  assign pendNext = active ? ((pend & ~issue) | evtVec) : '0;

  assign lfsrNext      = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign lfsrType      = 3'(lfsr % 8'd5);
  assign blockTypeNext = nextBlockTrue ? lfsrType : blockType;

  always_ff @(posedge clock) begin
    if (reset) begin
      btnSync1   <= '0;
      btnSync2   <= '0;
      btnDeb     <= '0;
      btnDebPrev <= '0;
      for (int i = 0; i < NumBtn; i++) debCnt[i] <= '0;
      gravCnt    <= '0;
      pend       <= '0;
      pulse      <= '0;
      lfsr       <= 8'hA5;
      blockType  <= 3'd0;
    end else begin
      btnSync1   <= btnRaw;
      btnSync2   <= btnSync1;
      btnDeb     <= btnDebNext;
      btnDebPrev <= btnDeb;
      for (int i = 0; i < NumBtn; i++) debCnt[i] <= debCntNext[i];
      gravCnt    <= gravCntNext;
      pend       <= pendNext;
      pulse      <= issue;
      lfsr       <= lfsrNext;
      blockType  <= blockTypeNext;
    end
  end

  assign rightTrue  = pulse[IdxRight];
  assign leftTrue   = pulse[IdxLeft];
  assign rotateTrue = pulse[IdxRotate];
  assign downTrue   = pulse[IdxDown];

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Directed bench for tetris_input_ctrl: debounce timing, priority, gravity, pause, reset, block
// type picking and (when TETRIS_AUTO_REPEAT_EN is defined) auto-repeat offsets.
module tb_tetris_input_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       btnLeft = 1'b0, btnRight = 1'b0, btnDown = 1'b0, btnRotate = 1'b0;
  logic       pause = 1'b0, gameOver = 1'b0, nextBlockTrue = 1'b0;
  logic       leftTrue, rightTrue, downTrue, rotateTrue;
  logic [2:0] blockType;

  int passCount  = 0;
  int checkCount = 0;
  int cyc;
  int multiCount;
  int tDown[$], tRotate[$], tLeft[$], tRight[$];
  logic [7:0] refLfsr;

  always #5 clock = ~clock;

  tetris_input_ctrl #(
    .DEBOUNCE_CYCLES(16),
    .GRAVITY_CYCLES (1024),
    .REPEAT_DELAY   (64),
    .REPEAT_RATE    (16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .btnLeft      (btnLeft),
    .btnRight     (btnRight),
    .btnDown      (btnDown),
    .btnRotate    (btnRotate),
    .pause        (pause),
    .gameOver     (gameOver),
    .nextBlockTrue(nextBlockTrue),
    .leftTrue     (leftTrue),
    .rightTrue    (rightTrue),
    .downTrue     (downTrue),
    .rotateTrue   (rotateTrue),
    .blockType    (blockType)
  );

  // Reference LFSR straight from the tap equation
  always @(posedge clock) begin
    if (reset) refLfsr <= 8'hA5;
    else       refLfsr <= {refLfsr[6:0], refLfsr[7] ^ refLfsr[5] ^ refLfsr[4] ^ refLfsr[3]};
  end

  task automatic checkVal(input string tag, input int got, input int exp);
    checkCount++;
    if (got == exp) passCount++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic clearLog();
    cyc = 0;
    multiCount = 0;
    tDown.delete();
    tRotate.delete();
    tLeft.delete();
    tRight.delete();
  endtask

  // cyc 0 is the first edge after clearLog
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
      if (downTrue)   tDown.push_back(cyc);
      if (rotateTrue) tRotate.push_back(cyc);
      if (leftTrue)   tLeft.push_back(cyc);
      if (rightTrue)  tRight.push_back(cyc);
      if (int'(downTrue) + int'(rotateTrue) + int'(leftTrue) + int'(rightTrue) > 1) multiCount++;
      cyc++;
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    btnLeft = 1'b0; btnRight = 1'b0; btnDown = 1'b0; btnRotate = 1'b0;
    pause = 1'b0; gameOver = 1'b0; nextBlockTrue = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    int expType;
    int gap;

    doReset();
    checkVal("rst pulses", {downTrue, rotateTrue, leftTrue, rightTrue}, 0);
    checkVal("rst blockType", blockType, 0);

    // Clean left press then release
    doReset();
    btnLeft = 1'b1;
    clearLog();
    run(40);
    btnLeft = 1'b0;
    run(40);
    checkVal("left count", tLeft.size(), 1);
    checkVal("left time", tLeft.size() > 0 ? tLeft[0] : -1, 19);
    checkVal("left others", tDown.size() + tRotate.size() + tRight.size(), 0);

    // Bouncing left never settles
    doReset();
    clearLog();
    for (int p = 0; p < 6; p++) begin
      btnLeft = (p % 2 == 0);
      run(5);
    end
    btnLeft = 1'b0;
    run(40);
    checkVal("bounce left", tLeft.size(), 0);

    // Rotate outranks left when both debounce together
    doReset();
    btnRotate = 1'b1;
    btnLeft = 1'b1;
    clearLog();
    run(40);
    checkVal("prio rotate time", tRotate.size() > 0 ? tRotate[0] : -1, 19);
    checkVal("prio left time", tLeft.size() > 0 ? tLeft[0] : -1, 20);
    checkVal("prio overlap", multiCount, 0);

    // Down press restarts the gravity period
    doReset();
    btnDown = 1'b1;
    clearLog();
    run(30);
    btnDown = 1'b0;
    run(1070);
    checkVal("down count", tDown.size(), 2);
    checkVal("down press time", tDown.size() > 0 ? tDown[0] : -1, 19);
    checkVal("down gravity time", tDown.size() > 1 ? tDown[1] : -1, 1043);

    // Idle gravity
    doReset();
    clearLog();
    run(3 * 1024 + 20);
    checkVal("grav count", tDown.size(), 3);
    checkVal("grav t0", tDown.size() > 0 ? tDown[0] : -1, 1024);
    checkVal("grav t1", tDown.size() > 1 ? tDown[1] : -1, 2048);
    checkVal("grav t2", tDown.size() > 2 ? tDown[2] : -1, 3072);
    checkVal("grav others", tRotate.size() + tLeft.size() + tRight.size(), 0);

    // Pause stretches gravity spacing
    doReset();
    clearLog();
    run(1101);
    pause = 1'b1;
    run(500);
    pause = 1'b0;
    run(1000);
    checkVal("pause count", tDown.size(), 2);
    checkVal("pause t0", tDown.size() > 0 ? tDown[0] : -1, 1024);
    checkVal("pause t1", tDown.size() > 1 ? tDown[1] : -1, 2548);

    // A press during gameOver is lost
    doReset();
    gameOver = 1'b1;
    btnLeft = 1'b1;
    clearLog();
    run(40);
    gameOver = 1'b0;
    run(40);
    checkVal("gameover left", tLeft.size(), 0);
    checkVal("gameover down", tDown.size(), 0);

    // Reset while a left event is pending discards it
    doReset();
    btnLeft = 1'b1;
    clearLog();
    run(19);
    reset = 1'b1;
    btnLeft = 1'b0;
    run(1);
    reset = 1'b0;
    run(40);
    checkVal("midrst left", tLeft.size(), 0);

    // Block type picks
    doReset();
    nextBlockTrue = 1'b1;
    run(1);
    checkVal("blk first", blockType, 0);   // 8'hA5 = 165, mod 5 = 0
    run(1);
    nextBlockTrue = 1'b0;
    checkVal("blk second", blockType, 4);  // 8'h4A = 74, mod 5 = 4
    for (int r = 0; r < 12; r++) begin
      gap = r % 3;
      pause = (r == 5 || r == 6);
      gameOver = (r == 9);
      expType = int'(refLfsr) % 5;
      nextBlockTrue = 1'b1;
      run(1);
      nextBlockTrue = 1'b0;
      checkVal($sformatf("blk req%0d", r), blockType, expType);
      checkVal($sformatf("blk range%0d", r), int'(blockType < 3'd5), 1);
      run(gap + 1);
      checkVal($sformatf("blk hold%0d", r), blockType, expType);
    end
    pause = 1'b0;
    gameOver = 1'b0;

    // Held right: auto-repeat offsets, or a single pulse without the feature
    doReset();
    btnRight = 1'b1;
    clearLog();
    run(200);
    btnRight = 1'b0;
    run(60);
`ifdef TETRIS_AUTO_REPEAT_EN
    checkVal("rpt count", tRight.size(), 10);
    for (int k = 0; k < 10; k++) begin
      checkVal($sformatf("rpt t%0d", k), k < tRight.size() ? tRight[k] : -1,
               (k == 0) ? 19 : 83 + 16 * (k - 1));
    end
`else
    checkVal("hold right count", tRight.size(), 1);
    checkVal("hold right time", tRight.size() > 0 ? tRight[0] : -1, 19);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/tetris_input_ctrl.md
TETRIS_INPUT_CTRL -- requirements
Module: tetris_input_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required before a synchronised button changes debounced state.
REQ-002 Parameter GRAVITY_CYCLES, default 1024: period of the gravity down event, in clocks.
REQ-003 Parameter REPEAT_DELAY, default 64; parameter REPEAT_RATE, default 16: auto-repeat timing, used only under AUTO_REPEAT_EN.
REQ-004 clock  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 btnLeft, btnRight, btnDown, btnRotate  input  1 each  raw asynchronous push-buttons, active-high.
REQ-007 pause  input  1  level; high freezes gameplay events.
REQ-008 gameOver  input  1  level from the field stage; high freezes gameplay events.
REQ-009 nextBlockTrue  input  1  one-cycle request from the field stage for a new block type.
REQ-010 leftTrue, rightTrue, downTrue, rotateTrue  output  1 each  registered one-cycle move pulses to the field stage.
REQ-011 blockType  output  3  registered next-block type, range 0..4.

Function
REQ-012 Each button passes through a 2-flop synchroniser before any other use.
REQ-013 Each button has a debounce counter: it clears when the synchronised value equals the debounced state; otherwise it increments, and the debounced state toggles when the count reaches DEBOUNCE_CYCLES.
REQ-014 A press event is a debounced 0->1 transition; releases generate no event.
REQ-015 For a clean rising edge, the pulse asserts exactly DEBOUNCE_CYCLES+3 clocks after the first edge that samples the raw input high, provided no higher-priority event is pending.
REQ-016 Gravity counter counts 0..GRAVITY_CYCLES-1 and wraps; it raises a gravity event on wrap.
REQ-017 A down press event resets the gravity counter to 0 in the same cycle, so no extra gravity event is produced for that step.
REQ-018 Four pending flags (down, rotate, left, right) latch events; gravity and down-button events share the down flag.
REQ-019 Each cycle, the highest-priority set flag is issued as its pulse and cleared; priority order is down > rotate > left > right.
REQ-020 At most one output pulse is high in any cycle.
REQ-021 If a new event arrives for a flag in the same cycle that flag is issued, the flag stays set and issues again later; events are never lost, and repeated events coalesce while pending.
REQ-022 While pause or gameOver is high: no pulses, pending flags held at 0, gravity and repeat counters frozen; debouncers and LFSR keep running.
REQ-023 On resume, the gravity counter continues from its frozen value.
REQ-024 8-bit Fibonacci LFSR steps every cycle: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}; period 255; never all-zero.
REQ-025 On nextBlockTrue, blockType <= lfsr mod 5 on the next edge, using the LFSR value present in the request cycle.
REQ-026 blockType is held stable between requests; nextBlockTrue is honoured even while paused or game over.

Reset
REQ-027 On reset: all pulses 0, blockType 0, pending flags 0, synchronisers 0, debounced states 0, all counters 0, lfsr 8'hA5.
REQ-028 Reset asserted mid-operation discards all pending and partially debounced events within one clock; no pulse is issued in the cycle after reset.

Configuration
REQ-029 With macro TETRIS_AUTO_REPEAT_EN defined, a held left, right or down button (debounced high) produces extra press events REPEAT_DELAY cycles after its press event, then every REPEAT_RATE cycles until release; each button has its own repeat counter, cleared on release.
REQ-030 Without TETRIS_AUTO_REPEAT_EN, only debounced press edges generate events and no repeat counters are built.

Verification
REQ-031 Reset, then btnLeft high for 40 cycles -> exactly one leftTrue pulse, at cycle 19 after the first sampled edge; no other pulses.
REQ-032 btnLeft bounce (toggle every 5 cycles for 30 cycles), then low -> no leftTrue pulse.
REQ-033 btnRotate and btnLeft debounced in the same cycle -> rotateTrue in cycle N, leftTrue in cycle N+1.
REQ-034 Idle for 3*GRAVITY_CYCLES cycles -> exactly 3 downTrue pulses spaced 1024 cycles apart; with pause high for 500 cycles in between -> spacing stretched by 500.
REQ-035 nextBlockTrue pulses immediately after reset and repeatedly afterwards -> blockType always 0..4 and matches the reference-model LFSR mod 5 at each request.
REQ-036 With TETRIS_AUTO_REPEAT_EN, btnRight held for 200 cycles after debounce -> rightTrue pulses at offsets 0, 64, 80, 96, ... 192 relative to the first pulse.
